// File: rtl/vlsu_store_txn_tracker.sv
// In-order store-completion tracker for the VLSU AXI write path: queues store instructions,
// caps in-flight AW bursts and commits each instruction when its last B returns.
// Optional statistics counters are enabled with `define VLSU_TXN_TRACKER_STATS_EN.
module vlsu_store_txn_tracker #(
  parameter  int unsigned NrInsn         = 4,
  parameter  int unsigned MaxTxnPerInsn  = 256,
  parameter  int unsigned MaxOutstanding = 8,
  parameter  int unsigned IdWidth        = 3,
  localparam int unsigned TxnCntW        = $clog2(MaxTxnPerInsn + 1),
  localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               insn_valid_i,
  output logic               insn_ready_o,
  input  logic [IdWidth-1:0] insn_id_i,
  input  logic [TxnCntW-1:0] insn_txn_num_i,
  input  logic               aw_valid_i,
  output logic               aw_ready_o,
  output logic               aw_valid_o,
  input  logic               aw_ready_i,
  input  logic               b_valid_i,
  output logic               b_ready_o,
  input  logic [1:0]         b_resp_i,
  output logic               cmt_valid_o,
  output logic [IdWidth-1:0] cmt_id_o,
  output logic               cmt_err_o,
  output logic               pending_o,
  output logic [OutW-1:0]    outstanding_o,
  output logic [31:0]        stat_b_cnt_o,
  output logic [31:0]        stat_stall_o
);

  localparam int unsigned PtrW = (NrInsn > 1) ? $clog2(NrInsn) : 1;
  localparam int unsigned CntW = $clog2(NrInsn + 1);

  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [TxnCntW-1:0] txn_num;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_e;

  entry_t            mem [NrInsn];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic [OutW-1:0]   out_q;
  state_e            state_q, state_d;
  logic [TxnCntW-1:0] rcv_q, rcv_d;
  logic              err_q, err_d;
  logic [TxnCntW:0]  rcv_sum;
  logic              full, push, pop, stall, aw_hs, b_hs, resp_err;
  logic              cmt_load, cmt_err_d;
  entry_t            head;

  // ---------------------------------------------------------------------------
  // Handshakes and AW cap
  // ---------------------------------------------------------------------------
  assign full          = (count == CntW'(NrInsn));
  assign insn_ready_o  = !full;
  assign pending_o     = (count != '0);
  assign push          = insn_valid_i & insn_ready_o;

  assign stall         = (out_q == OutW'(MaxOutstanding));
  assign aw_valid_o    = aw_valid_i & !stall;
  assign aw_ready_o    = aw_ready_i & !stall;
  assign aw_hs         = aw_valid_o & aw_ready_i;

  // Gating on out_q != 0 keeps the counter from underflowing on a stray B.
  assign b_ready_o     = pending_o & (out_q != '0);
  assign b_hs          = b_valid_i & b_ready_o;
  assign resp_err      = (b_resp_i == RespSlvErr) | (b_resp_i == RespDecErr);
  assign outstanding_o = out_q;

  assign head          = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  // NOTE: queue storage is not reset; validity is carried by count, so the
  // entries need no reset and can map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{id: insn_id_i, txn_num: insn_txn_num_i};
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   out_q <= out_q + OutW'(1);
        2'b01:   out_q <= out_q - OutW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head FSM: count B responses for the head instruction and pop it when done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rcv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcv_q   <= rcv_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rcv_d     = rcv_q;
    err_d     = err_q;
    pop       = 1'b0;
    cmt_load  = 1'b0;
    cmt_err_d = 1'b0;
    rcv_sum   = {1'b0, rcv_q} + (TxnCntW + 1)'(b_hs);
    case (state_q)
      S_IDLE: begin
        if (push) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (rcv_sum == {1'b0, head.txn_num}) begin
          pop       = 1'b1;
          cmt_load  = 1'b1;
          cmt_err_d = err_q | (b_hs & resp_err);
          rcv_d     = '0;
          err_d     = 1'b0;
          // Queue still holds an entry after this pop if more than one was
          // queued, or if a new one is pushed in the same cycle.
          state_d   = ((count > CntW'(1)) || push) ? S_COLLECT : S_IDLE;
        end else begin
          rcv_d = rcv_sum[TxnCntW-1:0];
          err_d = err_q | (b_hs & resp_err);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmt_valid_o <= 1'b0;
      cmt_id_o    <= '0;
      cmt_err_o   <= 1'b0;
    end else begin
      cmt_valid_o <= cmt_load;
      if (cmt_load) begin
        cmt_id_o  <= head.id;
        cmt_err_o <= cmt_err_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef VLSU_TXN_TRACKER_STATS_EN
  logic [31:0] stat_b_q, stat_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_b_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      if (b_hs && (stat_b_q != '1))                   stat_b_q     <= stat_b_q + 32'd1;
      if (aw_valid_i && stall && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_b_cnt_o = stat_b_q;
  assign stat_stall_o = stat_stall_q;
`else
  assign stat_b_cnt_o = '0;
  assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_vlsu_store_txn_tracker.sv
// Self-checking bench for vlsu_store_txn_tracker: a queue-level reference model compared on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_vlsu_store_txn_tracker;

  localparam int NR      = 4;
  localparam int MAX_OUT = 2;
  localparam int IDW     = 3;
  localparam int TXNW    = $clog2(256 + 1);
  localparam int OUTW    = $clog2(MAX_OUT + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            insn_valid_i = 1'b0;
  logic            insn_ready_o;
  logic [IDW-1:0]  insn_id_i = '0;
  logic [TXNW-1:0] insn_txn_num_i = '0;
  logic            aw_valid_i = 1'b0;
  logic            aw_ready_o;
  logic            aw_valid_o;
  logic            aw_ready_i = 1'b0;
  logic            b_valid_i = 1'b0;
  logic            b_ready_o;
  logic [1:0]      b_resp_i = 2'b00;
  logic            cmt_valid_o;
  logic [IDW-1:0]  cmt_id_o;
  logic            cmt_err_o;
  logic            pending_o;
  logic [OUTW-1:0] outstanding_o;
  logic [31:0]     stat_b_cnt_o;
  logic [31:0]     stat_stall_o;

  vlsu_store_txn_tracker #(
    .NrInsn(NR), .MaxTxnPerInsn(256), .MaxOutstanding(MAX_OUT), .IdWidth(IDW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .insn_valid_i(insn_valid_i), .insn_ready_o(insn_ready_o),
    .insn_id_i(insn_id_i), .insn_txn_num_i(insn_txn_num_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .cmt_valid_o(cmt_valid_o), .cmt_id_o(cmt_id_o), .cmt_err_o(cmt_err_o),
    .pending_o(pending_o), .outstanding_o(outstanding_o),
    .stat_b_cnt_o(stat_b_cnt_o), .stat_stall_o(stat_stall_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: list of queued instructions plus simple counters
  // ---------------------------------------------------------------------------
  typedef struct {
    int id;
    int txn;
  } ent_t;

  ent_t   mq[$];
  int     m_out = 0;
  int     m_rcv = 0;
  bit     m_err = 0;
  bit     m_cv = 0;
  int     m_cid = 0;
  bit     m_cerr = 0;
  longint m_bcnt = 0;
  longint m_stall = 0;

  bit s_stall, s_aw, s_b, s_push, s_berr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_out = 0; m_rcv = 0; m_err = 0;
      m_cv = 0; m_cid = 0; m_cerr = 0;
      m_bcnt = 0; m_stall = 0;
    end else begin
      s_stall = (m_out == MAX_OUT);
      s_aw    = aw_valid_i && aw_ready_i && !s_stall;
      s_b     = b_valid_i && (mq.size() != 0) && (m_out != 0);
      s_push  = insn_valid_i && (mq.size() < NR);
      s_berr  = s_b && (b_resp_i >= 2'd2);
      if (aw_valid_i && s_stall) m_stall++;
      if (s_b) m_bcnt++;
      m_out = m_out + (s_aw ? 1 : 0) - (s_b ? 1 : 0);
      m_cv = 0;
      if (mq.size() != 0) begin
        if (m_rcv + (s_b ? 1 : 0) == mq[0].txn) begin
          m_cv   = 1;
          m_cid  = mq[0].id;
          m_cerr = m_err | s_berr;
          void'(mq.pop_front());
          m_rcv  = 0;
          m_err  = 0;
        end else begin
          m_rcv = m_rcv + (s_b ? 1 : 0);
          m_err = m_err | s_berr;
        end
      end
      if (s_push) mq.push_back('{int'(insn_id_i), int'(insn_txn_num_i)});
    end
  end

  bit c_stall;
  always @(negedge clk) begin
    c_stall = (m_out == MAX_OUT);
    check("m_insn_ready", insn_ready_o, mq.size() < NR);
    check("m_pending", pending_o, mq.size() != 0);
    check("m_outstanding", outstanding_o, m_out);
    check("m_aw_valid", aw_valid_o, aw_valid_i && !c_stall);
    check("m_aw_ready", aw_ready_o, aw_ready_i && !c_stall);
    check("m_b_ready", b_ready_o, (mq.size() != 0) && (m_out != 0));
    check("m_cmt_valid", cmt_valid_o, m_cv);
    if (m_cv) begin
      check("m_cmt_id", cmt_id_o, m_cid);
      check("m_cmt_err", cmt_err_o, m_cerr);
    end
`ifdef VLSU_TXN_TRACKER_STATS_EN
    check("m_stat_b", stat_b_cnt_o, m_bcnt[31:0]);
    check("m_stat_stall", stat_stall_o, m_stall[31:0]);
`else
    check("m_stat_b", stat_b_cnt_o, 0);
    check("m_stat_stall", stat_stall_o, 0);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int txn);
    bit done = 0;
    insn_valid_i = 1'b1;
    insn_id_i = IDW'(id);
    insn_txn_num_i = TXNW'(txn);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = insn_ready_o;
      step();
    end
    insn_valid_i = 1'b0;
    check("push_timeout", done, 1);
  endtask

  task automatic aw_one();
    bit done = 0;
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = aw_valid_o;
      step();
    end
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
    check("aw_timeout", done, 1);
  endtask

  task automatic b_one(input logic [1:0] resp);
    bit done = 0;
    b_valid_i = 1'b1;
    b_resp_i = resp;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = b_ready_o;
      step();
    end
    b_valid_i = 1'b0;
    b_resp_i = 2'b00;
    check("b_timeout", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int pulses;

  initial begin
    // Reset values, with AW inputs showing the pass-through gating.
    aw_valid_i = 1'b1;
    #3;
    check("rst_insn_ready", insn_ready_o, 1);
    check("rst_pending", pending_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_b_ready", b_ready_o, 0);
    check("rst_cmt_valid", cmt_valid_o, 0);
    check("rst_cmt_id", cmt_id_o, 0);
    check("rst_cmt_err", cmt_err_o, 0);
    check("rst_aw_valid_follow", aw_valid_o, 1);
    check("rst_aw_ready_follow", aw_ready_o, 0);
    aw_valid_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Instruction id=1 with 3 transactions, exercising the AW cap of 2.
    push(1, 3);
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    @(negedge clk); check("cap_aw0", aw_valid_o, 1); step();
    @(negedge clk); check("cap_aw1", aw_valid_o, 1); step();
    @(negedge clk);
    check("cap_blocked_valid", aw_valid_o, 0);
    check("cap_blocked_ready", aw_ready_o, 0);
    check("cap_out_full", outstanding_o, 2);
    step();
    b_valid_i = 1'b1;
    @(negedge clk);
    check("cap_still_blocked", aw_valid_o, 0);
    check("cap_b_ready", b_ready_o, 1);
    step();
    b_valid_i = 1'b0;
    @(negedge clk);
    check("cap_unblocked", aw_valid_o, 1);
    check("cap_out_after_b", outstanding_o, 1);
`ifdef VLSU_TXN_TRACKER_STATS_EN
    check("cap_stall_cycles", stat_stall_o, 2);
`endif
    step();
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
    b_one(2'b00);
    b_one(2'b00);
    @(negedge clk);
    check("t1_cmt_valid", cmt_valid_o, 1);
    check("t1_cmt_id", cmt_id_o, 1);
    check("t1_cmt_err", cmt_err_o, 0);
    check("t1_pending", pending_o, 0);
    step();
    @(negedge clk);
    check("t1_single_pulse", cmt_valid_o, 0);
    step();

    // id=2 (two txns, second SLVERR) followed by zero-transaction id=3.
    push(2, 2);
    push(3, 0);
    aw_one();
    aw_one();
    b_one(2'b00);
    b_one(2'b10);
    @(negedge clk);
    check("t3_cmt2_valid", cmt_valid_o, 1);
    check("t3_cmt2_id", cmt_id_o, 2);
    check("t3_cmt2_err", cmt_err_o, 1);
    step();
    @(negedge clk);
    check("t3_cmt3_valid", cmt_valid_o, 1);
    check("t3_cmt3_id", cmt_id_o, 3);
    check("t3_cmt3_err", cmt_err_o, 0);
    check("t3_pending", pending_o, 0);
    step();

    // Full queue: a pop with insn_valid high does not push that cycle.
    push(4, 1);
    push(5, 1);
    push(6, 0);
    push(7, 0);
    @(negedge clk);
    check("t4_full", insn_ready_o, 0);
    step();
    aw_one();
    insn_valid_i = 1'b1;
    insn_id_i = 3'd0;
    insn_txn_num_i = '0;
    b_valid_i = 1'b1;
    @(negedge clk);
    check("t4_full_at_pop", insn_ready_o, 0);
    check("t4_b_ready", b_ready_o, 1);
    step();
    b_valid_i = 1'b0;
    @(negedge clk);
    check("t4_ready_after_pop", insn_ready_o, 1);
    check("t4_cmt4", cmt_id_o, 4);
    step();
    insn_valid_i = 1'b0;
    @(negedge clk);
    check("t4_full_again", insn_ready_o, 0);
    step();
    aw_one();
    b_one(2'b11);
    @(negedge clk);
    check("t4_cmt5_id", cmt_id_o, 5);
    check("t4_cmt5_err", cmt_err_o, 1);
    repeat (5) step();
    @(negedge clk);
    check("t4_drained", pending_o, 0);
    step();

    // Simultaneous AW and B handshakes at outstanding=1.
    push(1, 2);
    aw_one();
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    b_valid_i = 1'b1;
    @(negedge clk);
    check("t5_aw_ok", aw_valid_o, 1);
    check("t5_b_ok", b_ready_o, 1);
    step();
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
    b_valid_i = 1'b0;
    @(negedge clk);
    check("t5_out_same", outstanding_o, 1);
    check("t5_b_ready_same", b_ready_o, 1);
    step();
    b_one(2'b01);
    @(negedge clk);
    check("t5_cmt_id", cmt_id_o, 1);
    check("t5_cmt_err_exokay", cmt_err_o, 0);
    step();

    // Mid-operation reset discards everything.
    push(2, 3);
    push(3, 1);
    aw_one();
    aw_one();
    rst_n = 1'b0;
    #1;
    check("mr_pending", pending_o, 0);
    check("mr_outstanding", outstanding_o, 0);
    check("mr_b_ready", b_ready_o, 0);
    check("mr_insn_ready", insn_ready_o, 1);
    check("mr_cmt_valid", cmt_valid_o, 0);
    step();
    step();
    rst_n = 1'b1;
    b_valid_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmt_valid_o) pulses++;
      step();
    end
    b_valid_i = 1'b0;
    check("mr_no_commit", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
